// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: redirect request, IM read port and head-of-queue handshake.
// master: the fetch queue itself (drives im_addr, out_*, count).
// slave : the surroundings (IM, MEM-stage redirect, IF/ID register).
interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int IM_AW = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [IM_AW-1:0]  im_addr;
  logic [31:0]       im_data;
  logic              out_valid;
  logic [31:0]       out_pc;
  logic [31:0]       out_ir;
  logic              out_ready;
  logic [CW-1:0]     count;

  modport master (
    input  redirect, redirect_pc, im_data, out_ready,
    output im_addr, out_valid, out_pc, out_ir, count
  );

  modport slave (
    output redirect, redirect_pc, im_data, out_ready,
    input  im_addr, out_valid, out_pc, out_ir, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between IM and IF/ID; owns the fetch PC.
// Latency: an entry pushed at edge N is at the head after edge N (empty queue).
// Backpressure: out_ready=0 holds the head; when full, fetch_pc and im_addr freeze.
// Ports: clk, rst (async, active-high); bus (fetch_queue_if.master):
//   redirect/redirect_pc in, im_addr out / im_data in,
//   out_valid/out_pc/out_ir out with out_ready in, count out (occupancy).
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IM_AW    = 5
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.master  bus
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Storage is not reset: out_* are gated by occupancy, so stale words never show.
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   ir_mem_q [DEPTH];

  logic          head_vld;
  logic          pop;
  logic          push;

  assign head_vld = (count_q != '0);
  assign pop      = head_vld && bus.out_ready;
  // A full queue that pops this cycle frees the slot it writes into.
  assign push     = !bus.redirect && ((count_q != FULL) || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (bus.redirect) begin
      // Flush: the popped head (if any) is discarded with the rest.
      fetch_pc_d = bus.redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem_q[wr_ptr_q] <= fetch_pc_q + 32'd4;
      ir_mem_q[wr_ptr_q] <= bus.im_data;
    end
  end

  // Outputs depend on registered state only; empty queue presents a NOP.
  assign bus.im_addr   = fetch_pc_q[IM_AW+1:2];
  assign bus.out_valid = head_vld;
  assign bus.out_pc    = head_vld ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign bus.out_ir    = head_vld ? ir_mem_q[rd_ptr_q] : 32'h0;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: IM model with IM[k]=k+1, scoreboard of expected
// {PC+4, IR} entries pushed when the model pushes, compared at the head.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int IM_AW = 5;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  logic clk;
  logic rst;
  logic [31:0] im_mem [32];

  fetch_queue_if #(.DEPTH(DEPTH), .IM_AW(IM_AW)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .IM_AW(IM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fq.master)
  );

  assign fq.im_data = im_mem[fq.im_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  exp_t exp_q [$];
  logic [31:0] m_pc;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] im_word(input logic [31:0] pc);
    logic [4:0] a;
    a = pc[6:2];
    return im_mem[a];
  endfunction

  // Called just after a negedge: drive inputs, check head, advance model, wait one cycle.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic m_pop;
    logic m_push;
    exp_t e;
    fq.out_ready   = rdy;
    fq.redirect    = redir;
    fq.redirect_pc = rpc;
    #1;
    chk_eq("count", 32'(fq.count), 32'(exp_q.size()));
    chk_eq("valid", 32'(fq.out_valid), 32'(exp_q.size() != 0));
    chk_eq("im_addr", 32'(fq.im_addr), {27'd0, m_pc[6:2]});
    if (exp_q.size() != 0) begin
      chk_eq("head_pc", fq.out_pc, exp_q[0].pc);
      chk_eq("head_ir", fq.out_ir, exp_q[0].ir);
    end else begin
      chk_eq("empty_pc", fq.out_pc, 32'h0);
      chk_eq("empty_ir", fq.out_ir, 32'h0);
    end
    m_pop  = (exp_q.size() != 0) && rdy;
    m_push = !redir && ((exp_q.size() < DEPTH) || m_pop);
    if (redir) begin
      exp_q.delete();
      m_pc = rpc;
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        e.pc = m_pc + 32'd4;
        e.ir = im_word(m_pc);
        exp_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk_eq("rst_count", 32'(fq.count), 32'h0);
    chk_eq("rst_valid", 32'(fq.out_valid), 32'h0);
    chk_eq("rst_pc", fq.out_pc, 32'h0);
    chk_eq("rst_ir", fq.out_ir, 32'h0);
    chk_eq("rst_im_addr", 32'(fq.im_addr), 32'h0);
    rst = 1'b0;
    exp_q.delete();
    m_pc = 32'h0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    m_pc = 32'h0;
    for (int k = 0; k < 32; k++) im_mem[k] = k + 1;
    fq.out_ready   = 1'b0;
    fq.redirect    = 1'b0;
    fq.redirect_pc = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // 1: streaming with out_ready=1 from reset
    do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    chk_eq("t1_valid", 32'(fq.out_valid), 32'h1);
    chk_eq("t1_pc", fq.out_pc, 32'h4);
    chk_eq("t1_ir", fq.out_ir, 32'h1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk_eq("t1_count", 32'(fq.count), 32'h1);
    end

    // 2/3: stall from reset, fill, freeze, then release
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    chk_eq("t2_full", 32'(fq.count), 32'h4);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);
    chk_eq("t2_hold_count", 32'(fq.count), 32'h4);
    chk_eq("t2_hold_addr", 32'(fq.im_addr), 32'h4);
    for (int k = 1; k <= 5; k++) begin
      chk_eq("t2_seq", fq.out_ir, 32'(k));
      cycle(1'b1, 1'b0, 32'h0);
      if (k == 1) chk_eq("t3_full_pop_push", 32'(fq.count), 32'h4);
    end

    // 4: redirect with count=3
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    chk_eq("t4_pre", 32'(fq.count), 32'h3);
    cycle(1'b0, 1'b1, 32'h40);
    chk_eq("t4_count", 32'(fq.count), 32'h0);
    chk_eq("t4_valid", 32'(fq.out_valid), 32'h0);
    chk_eq("t4_ir0", fq.out_ir, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk_eq("t4_pc", fq.out_pc, 32'h44);
    chk_eq("t4_ir", fq.out_ir, 32'd17);

    // 5: redirect together with a pop while full
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h20);
    chk_eq("t5_count", 32'(fq.count), 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk_eq("t5_pc", fq.out_pc, 32'h24);
    chk_eq("t5_ir", fq.out_ir, 32'd9);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);

    // 6: asynchronous reset between edges with count=2
    do_reset();
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk_eq("t6_pre", 32'(fq.count), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk_eq("t6_valid", 32'(fq.out_valid), 32'h0);
    chk_eq("t6_count", 32'(fq.count), 32'h0);
    chk_eq("t6_im_addr", 32'(fq.im_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_pc = 32'h0;
    cycle(1'b1, 1'b0, 32'h0);
    chk_eq("t6_restart_pc", fq.out_pc, 32'h4);
    chk_eq("t6_restart_ir", fq.out_ir, 32'h1);

    // PC wrap at 2^32
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);

    // Random ready / redirect traffic, including back-to-back redirects
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom & 32'hFFFF_FFFC);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
